// File: rtl/hazard_scoreboard.sv
// Purpose: tracks pending register-file writes in E/M/W and resolves D-stage operand hazards
//          (stall request or forward-source select per operand).
// Latency: stall/forward selects are combinational from current state and D inputs; state advances every cycle.
// Backpressure: none accepted; asserting stall injects a bubble into E while M and W keep draining.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   d_valid               D stage holds a real instruction
//   d_rs / d_rt           D-stage source addresses
//   d_use_rs / d_use_rt   instruction reads the operand
//   d_tuse_rs / d_tuse_rt cycles from D until the operand is needed (0=D, 1=E, 2=M)
//   d_wr_en / d_a3        instruction writes register d_a3
//   d_tnew                cycles after entering E until its result is forwardable
//   stall                 hold F/D, insert bubble into E
//   fwd_rs_sel/fwd_rt_sel 0=GRF 1=W 2=M 3=E
//   w_wr_en / w_a3        W-stage write enable and destination for the register file
//   stall_cnt             running count of stalled cycles (wraps)
module hazard_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_rs,
  input  logic [ADDR_W-1:0] d_rt,
  input  logic              d_use_rs,
  input  logic              d_use_rt,
  input  logic [1:0]        d_tuse_rs,
  input  logic [1:0]        d_tuse_rt,
  input  logic              d_wr_en,
  input  logic [ADDR_W-1:0] d_a3,
  input  logic [1:0]        d_tnew,
  output logic              stall,
  output logic [1:0]        fwd_rs_sel,
  output logic [1:0]        fwd_rt_sel,
  output logic              w_wr_en,
  output logic [ADDR_W-1:0] w_a3,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] a3;
    logic [1:0]        tnew;
  } entry_t;

  entry_t e_q, m_q, w_q;
  entry_t e_nxt;
  logic   rs_stall, rt_stall;

  // Remaining cycles until forwardable; saturates at zero so a ready result stays ready.
  function automatic logic [1:0] dec_sat(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Returns {stall, sel[1:0]} for one operand.
  function automatic logic [2:0] op_check(input entry_t e, input entry_t m, input entry_t w,
                                          input logic [ADDR_W-1:0] op, input logic live,
                                          input logic [1:0] tuse);
    logic       he, hm, hw, st;
    logic [1:0] sel;
    he  = e.vld && (e.a3 == op) && (op != '0) && live;
    hm  = m.vld && (m.a3 == op) && (op != '0) && live;
    hw  = w.vld && (w.a3 == op) && (op != '0) && live;
    st  = (he && (e.tnew > tuse)) || (hm && (m.tnew > tuse)) || (hw && (w.tnew > tuse));
    sel = 2'd0;
    // Only the youngest match counts: a not-yet-ready younger write hides an older ready one.
    if (he)      sel = (e.tnew == 2'd0) ? 2'd3 : 2'd0;
    else if (hm) sel = (m.tnew == 2'd0) ? 2'd2 : 2'd0;
    else if (hw) sel = (w.tnew == 2'd0) ? 2'd1 : 2'd0;
    return {st, sel};
  endfunction

  always_comb begin
    {rs_stall, fwd_rs_sel} = op_check(e_q, m_q, w_q, d_rs, d_valid && d_use_rs, d_tuse_rs);
    {rt_stall, fwd_rt_sel} = op_check(e_q, m_q, w_q, d_rt, d_valid && d_use_rt, d_tuse_rt);
    stall = rs_stall || rt_stall;

    e_nxt      = '0;
    e_nxt.vld  = d_valid && d_wr_en && (d_a3 != '0);
    e_nxt.a3   = d_a3;
    e_nxt.tnew = d_tnew;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q       <= '0;
      m_q       <= '0;
      w_q       <= '0;
      stall_cnt <= '0;
    end else begin
      w_q       <= '{vld: m_q.vld, a3: m_q.a3, tnew: dec_sat(m_q.tnew)};
      m_q       <= '{vld: e_q.vld, a3: e_q.a3, tnew: dec_sat(e_q.tnew)};
      e_q       <= stall ? entry_t'('0) : e_nxt;
      if (stall) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // The W entry doubles as the register-file write port; a W match forwards
  // because the file writes on the same edge the D-stage read would see stale data.
  assign w_wr_en = w_q.vld;
  assign w_a3    = w_q.a3;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Purpose: self-checking bench for hazard_scoreboard: directed vector table, reset sequences,
//          and randomized traffic against an age-based reference model.
// Latency: outputs are sampled on the falling edge; model state advances on each rising edge.
// Backpressure: n/a (bench drives every cycle).
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_valid;
  logic [4:0]  d_rs, d_rt, d_a3;
  logic        d_use_rs, d_use_rt, d_wr_en;
  logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
  logic        stall;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel;
  logic        w_wr_en;
  logic [4:0]  w_a3;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard #(.ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wr_en(d_wr_en), .d_a3(d_a3), .d_tnew(d_tnew), .stall(stall),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .w_wr_en(w_wr_en), .w_a3(w_a3),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: in-flight instructions indexed by age since entering E
  // (0 = in E, 1 = in M, 2 = in W), each remembering the latency it was issued with.
  logic        r_vld  [3];
  logic [4:0]  r_a3   [3];
  int          r_tnew [3];
  logic [15:0] r_cnt;

  task automatic model_clear();
    for (int a = 0; a < 3; a++) begin
      r_vld[a] = 1'b0; r_a3[a] = 5'd0; r_tnew[a] = 0;
    end
    r_cnt = 16'd0;
  endtask

  task automatic model_op(input logic [4:0] op, input logic use_op, input logic [1:0] tuse,
                          output logic st, output logic [1:0] sel);
    bit found = 0;
    int rem;
    st = 1'b0; sel = 2'd0;
    for (int a = 0; a < 3; a++) begin
      if (r_vld[a] && r_a3[a] == op && op != 0 && d_valid && use_op) begin
        rem = (r_tnew[a] > a) ? r_tnew[a] - a : 0;
        if (rem > int'(tuse)) st = 1'b1;
        if (!found) begin
          found = 1;
          sel = (rem == 0) ? 2'(3 - a) : 2'd0;
        end
      end
    end
  endtask

  task automatic model_eval(output logic st, output logic [1:0] rs_sel, output logic [1:0] rt_sel);
    logic s1, s2;
    model_op(d_rs, d_use_rs, d_tuse_rs, s1, rs_sel);
    model_op(d_rt, d_use_rt, d_tuse_rt, s2, rt_sel);
    st = s1 | s2;
  endtask

  task automatic model_update();
    logic st;
    logic [1:0] s_rs, s_rt;
    if (reset) begin
      model_clear();
    end else begin
      model_eval(st, s_rs, s_rt);
      if (st) r_cnt = r_cnt + 16'd1;
      for (int a = 2; a > 0; a--) begin
        r_vld[a] = r_vld[a-1]; r_a3[a] = r_a3[a-1]; r_tnew[a] = r_tnew[a-1];
      end
      if (st) begin
        r_vld[0] = 1'b0; r_a3[0] = 5'd0; r_tnew[0] = 0;
      end else begin
        r_vld[0]  = d_valid && d_wr_en && (d_a3 != 0);
        r_a3[0]   = d_a3;
        r_tnew[0] = int'(d_tnew);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [1:0] trs,
                        input logic [1:0] trt, input logic wr, input logic [4:0] a3,
                        input logic [1:0] tn);
    d_valid = v; d_rs = rs; d_rt = rt; d_use_rs = urs; d_use_rt = urt;
    d_tuse_rs = trs; d_tuse_rt = trt; d_wr_en = wr; d_a3 = a3; d_tnew = tn;
  endtask

  typedef struct {
    logic       v;
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [1:0] trs, trt;
    logic       wr;
    logic [4:0] a3;
    logic [1:0] tn;
    logic       e_st;
    logic [1:0] e_rs, e_rt;
    logic       e_w;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[17];

  initial begin
    logic       m_st;
    logic [1:0] m_rs, m_rt;

    //        v  rs  rt  urs urt trs trt wr a3  tn   st rs rt w  cnt
    tbl[0]  = '{1, 0,  0,  1,  0,  1,  0,  1, 1,  2,   0, 0, 0, 0, 0};  // lw $1
    tbl[1]  = '{1, 1,  0,  1,  1,  1,  1,  1, 4,  1,   1, 0, 0, 0, 0};  // add $4,$1 : load-use stall
    tbl[2]  = '{1, 1,  0,  1,  1,  1,  1,  1, 4,  1,   0, 0, 0, 0, 1};  // add retried, lw now in M
    tbl[3]  = '{1, 0,  0,  1,  1,  1,  1,  1, 2,  1,   0, 0, 0, 1, 1};  // add $2
    tbl[4]  = '{1, 2,  4,  1,  1,  0,  0,  0, 0,  0,   1, 0, 2, 0, 1};  // beq $2,$4 : stall, rt from M
    tbl[5]  = '{1, 2,  4,  1,  1,  0,  0,  0, 0,  0,   0, 2, 1, 1, 2};  // beq retried: rs M, rt W
    tbl[6]  = '{1, 0,  0,  0,  0,  0,  0,  1, 31, 0,   0, 0, 0, 1, 2};  // jal $31
    tbl[7]  = '{1, 31, 0,  1,  0,  0,  0,  0, 0,  0,   0, 3, 0, 0, 2};  // jr $31 : forward from E
    tbl[8]  = '{1, 0,  0,  0,  0,  0,  0,  1, 0,  2,   0, 0, 0, 0, 2};  // lw $0
    tbl[9]  = '{1, 0,  0,  1,  1,  0,  0,  0, 0,  0,   0, 0, 0, 1, 2};  // read $0 : never hazards
    tbl[10] = '{0, 0,  0,  0,  0,  0,  0,  0, 0,  0,   0, 0, 0, 0, 2};
    tbl[11] = '{0, 0,  0,  0,  0,  0,  0,  0, 0,  0,   0, 0, 0, 0, 2};  // $0 write reaches W invalid
    tbl[12] = '{1, 0,  0,  0,  0,  0,  0,  1, 3,  1,   0, 0, 0, 0, 2};  // add $3
    tbl[13] = '{1, 0,  0,  0,  0,  0,  0,  1, 3,  1,   0, 0, 0, 0, 2};  // add $3
    tbl[14] = '{1, 3,  0,  1,  0,  1,  0,  0, 0,  0,   0, 0, 0, 0, 2};  // young E hides ready M
    tbl[15] = '{1, 3,  0,  1,  0,  0,  0,  1, 3,  0,   0, 2, 0, 1, 2};  // M wins over W; writes $3
    tbl[16] = '{1, 3,  3,  1,  1,  0,  0,  0, 0,  0,   0, 3, 3, 1, 2};  // E wins, W copy ignored

    model_clear();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_rs_sel", 32'(fwd_rs_sel), 0);
    chk("rst_rt_sel", 32'(fwd_rt_sel), 0);
    chk("rst_w_wr_en", 32'(w_wr_en), 0);
    chk("rst_w_a3", 32'(w_a3), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    tick();

    for (int i = 0; i < 17; i++) begin
      set_in(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].trs, tbl[i].trt,
             tbl[i].wr, tbl[i].a3, tbl[i].tn);
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].e_st));
      chk($sformatf("vec%0d_rs_sel", i), 32'(fwd_rs_sel), 32'(tbl[i].e_rs));
      chk($sformatf("vec%0d_rt_sel", i), 32'(fwd_rt_sel), 32'(tbl[i].e_rt));
      chk($sformatf("vec%0d_w_wr_en", i), 32'(w_wr_en), 32'(tbl[i].e_w));
      chk($sformatf("vec%0d_stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].e_cnt));
      tick();
    end

    // Reset arriving while a load is pending and a dependent reader is stalled.
    set_in(1, 0, 0, 0, 0, 0, 0, 1, 5, 2);              // lw $5
    tick();
    set_in(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);              // reader of $5, tuse 0
    @(negedge clk);
    chk("mid_pre_stall", 32'(stall), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_post_stall", 32'(stall), 0);
    chk("mid_post_rs_sel", 32'(fwd_rs_sel), 0);
    chk("mid_post_cnt", 32'(stall_cnt), 0);
    chk("mid_post_w_wr_en", 32'(w_wr_en), 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("mid_drain%0d_w_wr_en", i), 32'(w_wr_en), 0);
      tick();
    end

    // Randomized traffic on a narrow register range so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      set_in(($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
             1'($urandom), 5'($urandom_range(0, 3)), 2'($urandom));
      @(negedge clk);
      model_eval(m_st, m_rs, m_rt);
      chk("rnd_stall", 32'(stall), 32'(m_st));
      chk("rnd_rs_sel", 32'(fwd_rs_sel), 32'(m_rs));
      chk("rnd_rt_sel", 32'(fwd_rt_sel), 32'(m_rt));
      chk("rnd_w_wr_en", 32'(w_wr_en), 32'(r_vld[2]));
      chk("rnd_w_a3", 32'(w_a3), 32'(r_a3[2]));
      chk("rnd_stall_cnt", 32'(stall_cnt), 32'(r_cnt));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
